iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu.sv | 191 +++++++++++++++++++
 tb/tb_iter_alu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith/shift/compare ops plus an optional
// N-cycle shift-add multiplier compiled in only when ITER_ALU_MUL_EN is defined.
module iter_alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   sell,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  output logic [N-1:0] ALUout,
  output logic         ZeroFlag,
  output logic         Cout
);

  localparam int SW = $clog2(N);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  logic          accept_s;
  logic          mul_req_s;
  logic [SW-1:0] shamt_s;
  logic [N:0]    sum_s;
  logic [N-1:0]  res_s;
  logic          cy_s;

  assign accept_s = in_valid & in_ready;
  assign shamt_s  = B[SW-1:0];

  // Single-cycle result and carry; MUL and unknown codes fall to zero here
  always_comb begin
    sum_s = '0;
    res_s = '0;
    cy_s  = 1'b0;
    case (sell)
      OP_AND:  res_s = A & B;
      OP_OR:   res_s = A | B;
      OP_XOR:  res_s = A ^ B;
      OP_ADD: begin
        sum_s = {1'b0, A} + {1'b0, B};
        res_s = sum_s[N-1:0];
        cy_s  = sum_s[N];
      end
      OP_SUB: begin
        sum_s = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};
        res_s = sum_s[N-1:0];
        cy_s  = sum_s[N];
      end
      OP_SLL:  res_s = A << shamt_s;
      OP_SRL:  res_s = A >> shamt_s;
      OP_SRA:  res_s = $signed(A) >>> shamt_s;
      OP_SLT:  res_s = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: res_s = {{(N-1){1'b0}}, (A < B)};
      default: res_s = '0;
    endcase
  end

`ifdef ITER_ALU_MUL_EN
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [N-1:0]  acc_r;
  logic [N-1:0]  mcand_r;
  logic [N-1:0]  mplier_r;
  logic [SW-1:0] cnt_r;
  logic [N-1:0]  mul_add_s;
  logic          mul_last_s;

  assign mul_req_s  = (sell == OP_MUL);
  assign mul_add_s  = acc_r + (mplier_r[0] ? mcand_r : {N{1'b0}});
  assign mul_last_s = (state_r == MUL) && (cnt_r == SW'(N - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && mul_req_s) begin
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (mul_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = MUL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: requests are taken only in IDLE and never during reset
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      IDLE:    in_ready = ~rst;
      MUL:     in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Shift-add multiplier, one multiplier bit per cycle, LSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
    end else if (accept_s && mul_req_s) begin
      acc_r    <= '0;
      mcand_r  <= A;
      mplier_r <= B;
      cnt_r    <= '0;
    end else if (state_r == MUL) begin
      acc_r    <= mul_add_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + SW'(1);
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
    end
  end
`else
  assign mul_req_s = 1'b0;

  // No multi-cycle op exists, so the block is ready whenever not in reset
  always_comb begin
    in_ready = ~rst;
  end
`endif

  // Registered result, flags and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALUout    <= '0;
      ZeroFlag  <= 1'b0;
      Cout      <= 1'b0;
    end else if (accept_s && !mul_req_s) begin
      out_valid <= 1'b1;
      ALUout    <= res_s;
      ZeroFlag  <= (res_s == {N{1'b0}});
      Cout      <= cy_s;
`ifdef ITER_ALU_MUL_EN
    end else if (mul_last_s) begin
      out_valid <= 1'b1;
      ALUout    <= mul_add_s;
      ZeroFlag  <= (mul_add_s == {N{1'b0}});
      Cout      <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      ALUout    <= ALUout;
      ZeroFlag  <= ZeroFlag;
      Cout      <= Cout;
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu (N=32); MUL steps follow ITER_ALU_MUL_EN.
module tb_iter_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sell;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic [31:0] ALUout;
  logic        ZeroFlag;
  logic        Cout;

  int tests;
  int fails;

  iter_alu #(.N(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sell(sell), .A(A), .B(B), .out_valid(out_valid), .ALUout(ALUout),
    .ZeroFlag(ZeroFlag), .Cout(Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    sell     = op;
    A        = a;
    B        = b;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [31:0] res,
                         input logic z, input logic c);
    chk({tag, ".ov"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".res"}, ALUout, res);
    chk({tag, ".z"}, {31'd0, ZeroFlag}, {31'd0, z});
    chk({tag, ".c"}, {31'd0, Cout}, {31'd0, c});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    drive(1'b0, 4'b0000, 32'd0, 32'd0);
    tick();
    tick();
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk_out("rst", 1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    drive(1'b1, 4'b0110, 32'd5, 32'd5);
    tick();
    chk_out("sub_eq", 1'b1, 32'd0, 1'b1, 1'b1);
    chk("sub_ready", {31'd0, in_ready}, 32'd1);

    drive(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk_out("add_wrap", 1'b1, 32'd0, 1'b1, 1'b1);
    drive(1'b1, 4'b0111, 32'h8000_0000, 32'd4);
    tick();
    chk_out("sra", 1'b1, 32'hF800_0000, 1'b0, 1'b0);

    drive(1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk_out("slt", 1'b1, 32'd1, 1'b0, 1'b0);
    drive(1'b1, 4'b1001, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk_out("sltu", 1'b1, 32'd0, 1'b1, 1'b0);

    drive(1'b1, 4'b0110, 32'd3, 32'd5);
    tick();
    chk_out("sub_neg", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    drive(1'b1, 4'b0010, 32'h1234_0000, 32'h0000_5678);
    tick();
    chk_out("add", 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    chk_out("undef", 1'b1, 32'd0, 1'b1, 1'b0);
    drive(1'b1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    chk_out("and", 1'b1, 32'h0000_F000, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    chk_out("or", 1'b1, 32'h0000_FFF0, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    chk_out("xor", 1'b1, 32'h0000_0FF0, 1'b0, 1'b0);
    drive(1'b1, 4'b0100, 32'd1, 32'h0000_0024);
    tick();
    chk_out("sll_shamt", 1'b1, 32'h0000_0010, 1'b0, 1'b0);
    drive(1'b1, 4'b0101, 32'h8000_0000, 32'd31);
    tick();
    chk_out("srl", 1'b1, 32'd1, 1'b0, 1'b0);

    drive(1'b0, 4'b0010, 32'd9, 32'd9);
    tick();
    chk_out("hold", 1'b0, 32'd1, 1'b0, 1'b0);

`ifdef ITER_ALU_MUL_EN
    drive(1'b1, 4'b1010, 32'd7, 32'd6);
    tick();
    drive(1'b1, 4'b0010, 32'd2, 32'd3);
    for (int i = 1; i <= 32; i++) begin
      chk("mul_busy_ready", {31'd0, in_ready}, 32'd0);
      chk("mul_busy_ov", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk_out("mul", 1'b1, 32'd42, 1'b0, 1'b0);
    chk("mul_done_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("held_add", 1'b1, 32'd5, 1'b0, 1'b0);

    drive(1'b1, 4'b1010, 32'd7, 32'd6);
    tick();
    drive(1'b0, 4'b0000, 32'd0, 32'd0);
    for (int i = 1; i < 10; i++) begin
      tick();
    end
`else
    drive(1'b1, 4'b1010, 32'd7, 32'd6);
    tick();
    chk_out("mul_unsup", 1'b1, 32'd0, 1'b1, 1'b0);
    chk("mul_unsup_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 4'b0010, 32'd4, 32'd4);
    tick();
    chk_out("pre_rst_add", 1'b1, 32'd8, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 32'd0, 32'd0);
`endif
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk_out("rst_mid", 1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 4'b0010, 32'd2, 32'd3);
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_out("post_rst_add", 1'b1, 32'd5, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 32'd0, 32'd0);
    for (int i = 0; i < 35; i++) begin
      tick();
      chk("no_stray_ov", {31'd0, out_valid}, 32'd0);
    end
    chk("final_hold", ALUout, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
